// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_access_arbiter
// Two-port arbiter and setup/strobe/hold sequencer for a 16x4 async RAM.
// Revision : 1.0
// ============================================================================
module ram_access_arbiter #(
  parameter int unsigned STROBE_CYCLES = 1,
  parameter bit          ROUND_ROBIN   = 1'b1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [3:0] a_addr,
  input  logic [3:0] a_wdata,
  output logic       a_ack,
  output logic [3:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [3:0] b_addr,
  input  logic [3:0] b_wdata,
  output logic       b_ack,
  output logic [3:0] b_rdata,
  output logic [3:0] ram_address,
  inout  wire  [3:0] ram_data,
  output logic       ram_nwrite_enable,
  output logic       ram_nread_enable
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       port_b_q, port_b_d;
  logic       last_b_q, last_b_d;
  logic       nwe_q, nwe_d;
  logic       nre_q, nre_d;
  logic       oe_q, oe_d;
  logic       a_ack_q, a_ack_d;
  logic       b_ack_q, b_ack_d;
  logic [3:0] a_rdata_q, a_rdata_d;
  logic [3:0] b_rdata_q, b_rdata_d;
  logic       grant_b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    port_b_d  = port_b_q;
    last_b_d  = last_b_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    grant_b   = b_req && (!a_req || (ROUND_ROBIN && !last_b_q));

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          state_d  = SETUP;
          port_b_d = grant_b;
          last_b_d = grant_b;
          addr_d   = grant_b ? b_addr  : a_addr;
          we_d     = grant_b ? b_we    : a_we;
          wdata_d  = grant_b ? b_wdata : a_wdata;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CNT_LOAD;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          if (!we_q) begin
            if (port_b_q) b_rdata_d = ram_data;
            else          a_rdata_d = ram_data;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes, bus enable and acks are decoded from the next state so every
    // RAM-facing control comes straight out of a flop.
    nwe_d   = !((state_d == STROBE) && we_d);
    nre_d   = !((state_d == STROBE) && !we_d);
    oe_d    = we_d && (state_d != IDLE);
    a_ack_d = (state_d == HOLD) && !port_b_d;
    b_ack_d = (state_d == HOLD) && port_b_d;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 4'd0;
      wdata_q   <= 4'd0;
      we_q      <= 1'b0;
      port_b_q  <= 1'b0;
      last_b_q  <= 1'b1;
      nwe_q     <= 1'b1;
      nre_q     <= 1'b1;
      oe_q      <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= 4'd0;
      b_rdata_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      port_b_q  <= port_b_d;
      last_b_q  <= last_b_d;
      nwe_q     <= nwe_d;
      nre_q     <= nre_d;
      oe_q      <= oe_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign ram_address       = addr_q;
  assign ram_data          = oe_q ? wdata_q : 4'bz;
  assign ram_nwrite_enable = nwe_q;
  assign ram_nread_enable  = nre_q;
  assign a_ack             = a_ack_q;
  assign b_ack             = b_ack_q;
  assign a_rdata           = a_rdata_q;
  assign b_rdata           = b_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_access_arbiter
// Directed bench: three arbiter instances (SC=1/RR=1, SC=1/RR=0, SC=3/RR=1).
// Revision : 1.0
// ============================================================================
module tb_ram_access_arbiter;

  logic            clk;
  logic            nreset;
  logic [2:0]      a_req, a_we, b_req, b_we;
  logic [2:0][3:0] a_addr, a_wdata, b_addr, b_wdata;
  wire  [2:0]      a_ack, b_ack, nwe, nre;
  wire  [2:0][3:0] a_rdata, b_rdata, ram_address;

  int n_checks = 0;
  int n_fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wire  [3:0] ram_data;
    logic [3:0] mem [16];
    logic       prev_low;
    logic [3:0] prev_addr;

    ram_access_arbiter #(
      .STROBE_CYCLES((g == 2) ? 3 : 1),
      .ROUND_ROBIN  ((g == 1) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk              (clk),
      .nreset           (nreset),
      .a_req            (a_req[g]),
      .a_we             (a_we[g]),
      .a_addr           (a_addr[g]),
      .a_wdata          (a_wdata[g]),
      .a_ack            (a_ack[g]),
      .a_rdata          (a_rdata[g]),
      .b_req            (b_req[g]),
      .b_we             (b_we[g]),
      .b_addr           (b_addr[g]),
      .b_wdata          (b_wdata[g]),
      .b_ack            (b_ack[g]),
      .b_rdata          (b_rdata[g]),
      .ram_address      (ram_address[g]),
      .ram_data         (ram_data),
      .ram_nwrite_enable(nwe[g]),
      .ram_nread_enable (nre[g])
    );

    // Asynchronous RAM: drives the bus while read strobe is low, latches on write release
    assign ram_data = nre[g] ? 4'bz : mem[ram_address[g]];
    always @(posedge nwe[g]) mem[ram_address[g]] <= ram_data;

    always @(negedge clk) begin
      if (nreset) begin
        n_checks++;
        if (!nwe[g] && !nre[g]) begin
          n_fails++;
          $display("FAIL strobes_both_low[%0d]: nwe=%b nre=%b, required not both 0", g, nwe[g], nre[g]);
        end
        if (!nre[g]) begin
          n_checks++;
          if (ram_data !== mem[ram_address[g]]) begin
            n_fails++;
            $display("FAIL bus_contention[%0d]: bus=%h, required RAM word %h", g, ram_data, mem[ram_address[g]]);
          end
        end
        if (prev_low && (!nwe[g] || !nre[g])) begin
          n_checks++;
          if (ram_address[g] !== prev_addr) begin
            n_fails++;
            $display("FAIL addr_stable[%0d]: addr=%h, required %h", g, ram_address[g], prev_addr);
          end
        end
        prev_low  = !nwe[g] || !nre[g];
        prev_addr = ram_address[g];
      end else begin
        prev_low = 1'b0;
      end
    end
  end

  task automatic clear_reqs();
    a_req = '0; b_req = '0; a_we = '0; b_we = '0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
  endtask

  task automatic pulse_reset();
    clear_reqs();
    @(negedge clk); nreset = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
  endtask

  // One bounded access; lat = edges from request to ack, -1 on timeout.
  task automatic do_access(input int g, input bit pb, input bit we,
                           input logic [3:0] addr, input logic [3:0] wd,
                           output int lat, output logic [3:0] rd,
                           output int strb, output bit addr_ok, output bit wrong_ack);
    bit done = 1'b0;
    lat = 0; strb = 0; addr_ok = 1'b1; wrong_ack = 1'b0; rd = '0;
    @(posedge clk); #1;
    if (pb) begin b_req[g] = 1'b1; b_we[g] = we; b_addr[g] = addr; b_wdata[g] = wd; end
    else    begin a_req[g] = 1'b1; a_we[g] = we; a_addr[g] = addr; a_wdata[g] = wd; end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (!nre[g] || !nwe[g]) begin
        strb++;
        if (ram_address[g] !== addr) addr_ok = 1'b0;
      end
      if (pb ? a_ack[g] : b_ack[g]) wrong_ack = 1'b1;
      if (pb ? b_ack[g] : a_ack[g]) begin
        rd = pb ? b_rdata[g] : a_rdata[g];
        done = 1'b1;
        break;
      end
    end
    a_req[g] = 1'b0; b_req[g] = 1'b0;
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    bit   saw_low = 1'b0;
    bit   saw_ack = 1'b0;
    @(posedge clk); #1;
    a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 4'h2; a_wdata[0] = 4'h5;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!nwe[0]) begin saw_low = 1'b1; break; end
    end
    n_checks++;
    if (!saw_low) begin n_fails++; $display("FAIL reset_write_started: nwe never low, required low"); end
    a_req[0] = 1'b0;
    #2 nreset = 1'b0;
    #1;
    n_checks++;
    if (nwe[0] !== 1'b1 || nre[0] !== 1'b1) begin
      n_fails++; $display("FAIL reset_strobes: nwe=%b nre=%b, required 1 1", nwe[0], nre[0]);
    end
    n_checks++;
    if (g_dut[0].u_dut.oe_q !== 1'b0) begin
      n_fails++; $display("FAIL reset_bus_z: oe=%b, required 0 (bus z)", g_dut[0].u_dut.oe_q);
    end
    n_checks++;
    if (g_dut[0].u_dut.state_q !== 2'd0) begin
      n_fails++; $display("FAIL reset_fsm: state=%0d, required 0 (IDLE)", g_dut[0].u_dut.state_q);
    end
    n_checks++;
    if (ram_address[0] !== 4'h0 || a_rdata[0] !== 4'h0 || b_rdata[0] !== 4'h0) begin
      n_fails++; $display("FAIL reset_regs: addr=%h a_rdata=%h b_rdata=%h, required 0 0 0",
                          ram_address[0], a_rdata[0], b_rdata[0]);
    end
    repeat (3) begin @(negedge clk); if (a_ack[0]) saw_ack = 1'b1; end
    nreset = 1'b1;
    repeat (5) begin @(negedge clk); if (a_ack[0]) saw_ack = 1'b1; end
    n_checks++;
    if (saw_ack) begin n_fails++; $display("FAIL reset_no_ack: a_ack=1 seen, required 0"); end
  endtask

  task automatic test_write_read();
    int lat, strb; logic [3:0] rd; bit aok, wack;
    do_access(0, 1'b0, 1'b1, 4'h3, 4'h9, lat, rd, strb, aok, wack);
    n_checks++;
    if (lat != 3 || strb != 1) begin
      n_fails++; $display("FAIL wr_latency: lat=%0d strobe=%0d, required 3 1", lat, strb);
    end
    do_access(0, 1'b0, 1'b0, 4'h3, 4'h0, lat, rd, strb, aok, wack);
    n_checks++;
    if (lat != 3) begin n_fails++; $display("FAIL rd_latency: lat=%0d, required 3", lat); end
    n_checks++;
    if (rd !== 4'h9) begin n_fails++; $display("FAIL rd_data: a_rdata=%h, required 9", rd); end
    do_access(0, 1'b1, 1'b1, 4'h3, 4'hC, lat, rd, strb, aok, wack);
    n_checks++;
    if (a_rdata[0] !== 4'h9 || wack) begin
      n_fails++; $display("FAIL rdata_hold: a_rdata=%h wrong_ack=%b, required 9 0", a_rdata[0], wack);
    end
    do_access(0, 1'b1, 1'b0, 4'h3, 4'h0, lat, rd, strb, aok, wack);
    n_checks++;
    if (rd !== 4'hC || wack) begin
      n_fails++; $display("FAIL b_rd_data: b_rdata=%h wrong_ack=%b, required c 0", rd, wack);
    end
  endtask

  task automatic test_round_robin();
    bit order [4];
    int got = 0;
    pulse_reset();
    @(posedge clk); #1;
    a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 4'h4; a_wdata[0] = 4'h1;
    b_req[0] = 1'b1; b_we[0] = 1'b1; b_addr[0] = 4'h5; b_wdata[0] = 4'h2;
    for (int i = 0; i < 60 && got < 4; i++) begin
      @(posedge clk); #1;
      if (a_ack[0])      begin order[got] = 1'b0; got++; end
      else if (b_ack[0]) begin order[got] = 1'b1; got++; end
    end
    a_req[0] = 1'b0; b_req[0] = 1'b0;
    n_checks++;
    if (got != 4) begin n_fails++; $display("FAIL rr_count: acks=%0d, required 4", got); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (order[i] !== i[0]) begin
        n_fails++; $display("FAIL rr_order[%0d]: port=%s, required %s", i,
                            order[i] ? "B" : "A", i[0] ? "B" : "A");
      end
    end
  endtask

  task automatic test_fixed_priority();
    int  a_cnt = 0;
    int  b_cnt = 0;
    bit  b_done = 1'b0;
    @(posedge clk); #1;
    a_req[1] = 1'b1; a_addr[1] = 4'h1;
    b_req[1] = 1'b1; b_addr[1] = 4'h2;
    for (int i = 0; i < 60 && a_cnt < 4; i++) begin
      @(posedge clk); #1;
      if (a_ack[1]) a_cnt++;
      if (b_ack[1]) b_cnt++;
    end
    a_req[1] = 1'b0;
    n_checks++;
    if (a_cnt != 4 || b_cnt != 0) begin
      n_fails++; $display("FAIL fixed_prio: a_acks=%0d b_acks=%0d, required 4 0", a_cnt, b_cnt);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (b_ack[1]) begin b_done = 1'b1; break; end
    end
    b_req[1] = 1'b0;
    n_checks++;
    if (!b_done) begin n_fails++; $display("FAIL fixed_prio_b: b_ack=0, required 1 once a_req drops"); end
  endtask

  task automatic test_long_strobe();
    int lat, strb; logic [3:0] rd; bit aok, wack;
    do_access(2, 1'b0, 1'b1, 4'h7, 4'h6, lat, rd, strb, aok, wack);
    n_checks++;
    if (lat != 5 || strb != 3) begin
      n_fails++; $display("FAIL sc3_write: lat=%0d strobe=%0d, required 5 3", lat, strb);
    end
    do_access(2, 1'b0, 1'b0, 4'h7, 4'h0, lat, rd, strb, aok, wack);
    n_checks++;
    if (lat != 5 || strb != 3 || !aok) begin
      n_fails++; $display("FAIL sc3_read: lat=%0d strobe=%0d addr_ok=%b, required 5 3 1", lat, strb, aok);
    end
    n_checks++;
    if (rd !== 4'h6) begin n_fails++; $display("FAIL sc3_rdata: rdata=%h, required 6", rd); end
  endtask

  task automatic test_random_traffic();
    logic [3:0] sb [16];
    int lat, strb; logic [3:0] rd; bit aok, wack;
    for (int a = 0; a < 16; a++) begin
      sb[a] = 4'($urandom);
      do_access(0, a[0], 1'b1, 4'(a), sb[a], lat, rd, strb, aok, wack);
    end
    for (int n = 0; n < 1000; n++) begin
      bit         pb   = 1'($urandom);
      bit         we   = 1'($urandom);
      logic [3:0] addr = 4'($urandom);
      logic [3:0] wd   = 4'($urandom);
      do_access(0, pb, we, addr, wd, lat, rd, strb, aok, wack);
      n_checks++;
      if (lat != 3 || wack || !aok) begin
        n_fails++; $display("FAIL rand_access[%0d]: lat=%0d wrong_ack=%b addr_ok=%b, required 3 0 1",
                            n, lat, wack, aok);
      end
      if (we) sb[addr] = wd;
      else begin
        n_checks++;
        if (rd !== sb[addr]) begin
          n_fails++; $display("FAIL rand_read[%0d]: addr=%h rdata=%h, required %h", n, addr, rd, sb[addr]);
        end
      end
    end
  endtask

  initial begin
    clear_reqs();
    nreset = 1'b1;
    #1 nreset = 1'b0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    test_reset();
    test_write_read();
    test_round_robin();
    test_fixed_priority();
    test_long_strobe();
    test_random_traffic();
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
